wddl_inv_bank: RTL and testbench

Parametrised dual-rail (WDDL-style) inverter bank with built-in precharge/evaluate sequencing for the hardened AES datapath. It accepts a WIDTH-bit dual-rail word through a valid/ready handshake and inverts it by swapping rails. It drives the result only during a timed evaluate phase, and returns all rails to 0 during a timed precharge phase so every evaluation toggles the same number of wires. It sits between the S-box dual-rail logic and the round register, and replaces hand-instantiated single-rail inverter cells.

---
 rtl/wddl_pkg.sv | 29 ++
 rtl/wddl_pair_check.sv | 33 +++
 rtl/wddl_inv_bank.sv | 201 ++++++++++++++++++++
 tb/tb_wddl_inv_bank.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wddl_pkg.sv
// -----------------------------------------------------------------------------
// wddl_pkg
// Shared definitions for the dual-rail (WDDL-style) inverter bank:
//   - phase_e      : precharge / evaluate phase of the bank
//   - FAULT_CNT_W  : width of the saturating fault counter
//   - wddl_pair_t  : one dual-rail bit, {t, f}
//   - pair_invalid : 1 when a dual-rail pair is not one-hot (00 or 11)
// -----------------------------------------------------------------------------
package wddl_pkg;

  typedef enum logic {
    PRE  = 1'b0,
    EVAL = 1'b1
  } phase_e;

  localparam int FAULT_CNT_W = 8;
  localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = '1;

  typedef struct packed {
    logic t;
    logic f;
  } wddl_pair_t;

  // A legal dual-rail value has exactly one rail high.
  function automatic logic pair_invalid(input wddl_pair_t p);
    return ~(p.t ^ p.f);
  endfunction

endpackage

// File: rtl/wddl_pair_check.sv
// -----------------------------------------------------------------------------
// wddl_pair_check
// Combinational one-hot checker over a WIDTH-pair dual-rail word.
// Ports:
//   in_t        in  WIDTH  true rails
//   in_f        in  WIDTH  false rails
//   any_invalid out 1      high if any (t,f) pair is 00 or 11
// -----------------------------------------------------------------------------
module wddl_pair_check
  import wddl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic             any_invalid
);

  logic [WIDTH-1:0] pair_bad;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pair
      wddl_pair_t pair;
      assign pair.t       = in_t[gi];
      assign pair.f       = in_f[gi];
      assign pair_bad[gi] = pair_invalid(pair);
    end
  endgenerate

  assign any_invalid = |pair_bad;

endmodule

// File: rtl/wddl_inv_bank.sv
// -----------------------------------------------------------------------------
// wddl_inv_bank
// Dual-rail inverter bank with precharge/evaluate sequencing. A word accepted
// through in_valid/in_ready is inverted by swapping its rails and driven on
// out_t/out_f for at least EVAL_CYCLES cycles; afterwards every rail returns
// to 0 for at least PRE_CYCLES cycles before the next word may be accepted,
// so each evaluation toggles the same number of wires.
//
// Optional build macro: WDDL_FAULT_DETECT_EN
//   defined   : accepted words with a non one-hot pair set the sticky fault
//               flag and bump a saturating 8-bit fault counter.
//   undefined : fault/fault_cnt are tied to 0 and fault_clr is ignored.
//
// Parameters: WIDTH (pairs), PRE_CYCLES (>=1), EVAL_CYCLES (>=1)
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   in_valid   in  1      input word present
//   in_ready   out 1      word accepted this cycle if in_valid
//   in_t/in_f  in  WIDTH  input true/false rails
//   out_valid  out 1      evaluated word on the output
//   out_ready  in  1      consumer has taken the output
//   out_t/out_f out WIDTH inverted word (rails swapped), 0 in precharge
//   phase_eval out 1      1 in EVAL, 0 in PRE
//   fault      out 1      sticky invalid-pair flag
//   fault_cnt  out 8      saturating count of faulty accepted words
//   fault_clr  in  1      clears fault and fault_cnt
// -----------------------------------------------------------------------------
module wddl_inv_bank
  import wddl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_t,
  input  logic [WIDTH-1:0]       in_f,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_t,
  output logic [WIDTH-1:0]       out_f,
  output logic                   phase_eval,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  input  logic                   fault_clr
);

  localparam int CNT_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES);
  localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  phase_e           state_reg,     state_next;
  logic [CNT_W-1:0] pre_cnt_reg,   pre_cnt_next;
  logic [CNT_W-1:0] eval_cnt_reg,  eval_cnt_next;
  logic [WIDTH-1:0] out_t_reg,     out_t_next;
  logic [WIDTH-1:0] out_f_reg,     out_f_next;
  logic             out_valid_reg, out_valid_next;

  logic accept;

  // Handshake and phase are decoded from registers only, so there is no
  // combinational path from the input side to in_ready.
  assign in_ready   = (state_reg == PRE) && (pre_cnt_reg == PRE_LAST);
  assign phase_eval = (state_reg == EVAL);
  assign accept     = in_valid && in_ready;

  assign out_t     = out_t_reg;
  assign out_f     = out_f_reg;
  assign out_valid = out_valid_reg;

  // ---------------------------------------------------------------------------
  // Phase sequencer: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    eval_cnt_next  = eval_cnt_reg;
    out_t_next     = out_t_reg;
    out_f_next     = out_f_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      PRE: begin
        out_t_next     = '0;
        out_f_next     = '0;
        out_valid_next = 1'b0;
        if (accept) begin
          // Inversion in dual-rail is a pure rail swap; invalid pairs
          // (00/11) pass through swapped, i.e. unchanged.
          state_next     = EVAL;
          out_t_next     = in_f;
          out_f_next     = in_t;
          out_valid_next = 1'b1;
          eval_cnt_next  = CNT_ONE;
        end else if (pre_cnt_reg != PRE_LAST) begin
          pre_cnt_next = pre_cnt_reg + 1'b1;
        end
      end

      EVAL: begin
        // out_ready is only honoured once the minimum hold time has elapsed.
        if (out_ready && (eval_cnt_reg == EVAL_LAST)) begin
          state_next     = PRE;
          out_t_next     = '0;
          out_f_next     = '0;
          out_valid_next = 1'b0;
          pre_cnt_next   = '0;
        end else if (eval_cnt_reg != EVAL_LAST) begin
          eval_cnt_next = eval_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = PRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= PRE;
      pre_cnt_reg   <= '0;
      eval_cnt_reg  <= '0;
      out_t_reg     <= '0;
      out_f_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= pre_cnt_next;
      eval_cnt_reg  <= eval_cnt_next;
      out_t_reg     <= out_t_next;
      out_f_reg     <= out_f_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional invalid-pair monitor
  // ---------------------------------------------------------------------------
`ifdef WDDL_FAULT_DETECT_EN
  logic                   any_invalid;
  logic                   new_fault;
  logic                   fault_reg,     fault_next;
  logic [FAULT_CNT_W-1:0] fault_cnt_reg, fault_cnt_next;

  wddl_pair_check #(
    .WIDTH(WIDTH)
  ) u_pair_check (
    .in_t       (in_t),
    .in_f       (in_f),
    .any_invalid(any_invalid)
  );

  assign new_fault = accept && any_invalid;

  // A new fault in the same cycle as a clear wins: the clear empties the
  // counter and the new fault is counted on top of it.
  always_comb begin
    fault_next     = fault_reg;
    fault_cnt_next = fault_cnt_reg;
    if (new_fault) begin
      fault_next = 1'b1;
      if (fault_clr) begin
        fault_cnt_next = FAULT_CNT_W'(1);
      end else if (fault_cnt_reg != FAULT_CNT_MAX) begin
        fault_cnt_next = fault_cnt_reg + 1'b1;
      end
    end else if (fault_clr) begin
      fault_next     = 1'b0;
      fault_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_reg     <= 1'b0;
      fault_cnt_reg <= '0;
    end else begin
      fault_reg     <= fault_next;
      fault_cnt_reg <= fault_cnt_next;
    end
  end

  assign fault     = fault_reg;
  assign fault_cnt = fault_cnt_reg;
`else
  // Monitor not built: the clear input has nothing to act on.
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault            = 1'b0;
  assign fault_cnt        = '0;
`endif

endmodule

// File: tb/tb_wddl_inv_bank.sv
// -----------------------------------------------------------------------------
// tb_wddl_inv_bank
// Two instances: "a" with default timing (PRE=1, EVAL=1) and "b" with
// PRE=2, EVAL=3. A behavioural model tracks, per instance, whether a word
// is held, how long it has been held and how long the bank has been idle.
// -----------------------------------------------------------------------------
module tb_wddl_inv_bank;

  localparam int A_PRE  = 1;
  localparam int A_EVAL = 1;
  localparam int B_PRE  = 2;
  localparam int B_EVAL = 3;
`ifdef WDDL_FAULT_DETECT_EN
  localparam bit FD = 1'b1;
`else
  localparam bit FD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance a signals
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_t, a_in_f, a_out_t, a_out_f, a_fault_cnt;
  logic       a_phase_eval, a_fault, a_fault_clr;
  // instance b signals
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_t, b_in_f, b_out_t, b_out_f, b_fault_cnt;
  logic       b_phase_eval, b_fault, b_fault_clr;

  wddl_inv_bank #(.WIDTH(8), .PRE_CYCLES(A_PRE), .EVAL_CYCLES(A_EVAL)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_t(a_in_t), .in_f(a_in_f),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_t(a_out_t), .out_f(a_out_f),
    .phase_eval(a_phase_eval), .fault(a_fault), .fault_cnt(a_fault_cnt), .fault_clr(a_fault_clr)
  );

  wddl_inv_bank #(.WIDTH(8), .PRE_CYCLES(B_PRE), .EVAL_CYCLES(B_EVAL)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_t(b_in_t), .in_f(b_in_f),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_t(b_out_t), .out_f(b_out_f),
    .phase_eval(b_phase_eval), .fault(b_fault), .fault_cnt(b_fault_cnt), .fault_clr(b_fault_clr)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic       ma_busy, mb_busy;
  int         ma_age, mb_age, ma_idle, mb_idle;
  logic [7:0] ma_t, ma_f, mb_t, mb_f;
  logic       ma_fault, mb_fault;
  logic [7:0] ma_fcnt, mb_fcnt;
  logic       ma_acc, mb_acc, ma_bad, mb_bad;

  assign ma_acc = !ma_busy && a_in_valid && (ma_idle >= A_PRE);
  assign mb_acc = !mb_busy && b_in_valid && (mb_idle >= B_PRE);
  assign ma_bad = (~(a_in_t ^ a_in_f)) != 8'h00;
  assign mb_bad = (~(b_in_t ^ b_in_f)) != 8'h00;

  always @(posedge clk) begin : model_a
    if (!rst_n) begin
      ma_busy <= 1'b0; ma_age <= 0; ma_idle <= 0;
      ma_t <= 8'h00; ma_f <= 8'h00; ma_fault <= 1'b0; ma_fcnt <= 8'h00;
    end else begin
      if (ma_busy) begin
        if (a_out_ready && ma_age >= A_EVAL) begin
          ma_busy <= 1'b0; ma_idle <= 0;
        end else ma_age <= ma_age + 1;
      end else if (ma_acc) begin
        ma_busy <= 1'b1; ma_age <= 1; ma_t <= a_in_f; ma_f <= a_in_t;
      end else ma_idle <= ma_idle + 1;
      if (FD && ma_acc && ma_bad) begin
        ma_fault <= 1'b1;
        ma_fcnt  <= a_fault_clr ? 8'd1 : ((ma_fcnt == 8'd255) ? 8'd255 : ma_fcnt + 8'd1);
      end else if (FD && a_fault_clr) begin
        ma_fault <= 1'b0; ma_fcnt <= 8'd0;
      end
    end
  end

  always @(posedge clk) begin : model_b
    if (!rst_n) begin
      mb_busy <= 1'b0; mb_age <= 0; mb_idle <= 0;
      mb_t <= 8'h00; mb_f <= 8'h00; mb_fault <= 1'b0; mb_fcnt <= 8'h00;
    end else begin
      if (mb_busy) begin
        if (b_out_ready && mb_age >= B_EVAL) begin
          mb_busy <= 1'b0; mb_idle <= 0;
        end else mb_age <= mb_age + 1;
      end else if (mb_acc) begin
        mb_busy <= 1'b1; mb_age <= 1; mb_t <= b_in_f; mb_f <= b_in_t;
      end else mb_idle <= mb_idle + 1;
      if (FD && mb_acc && mb_bad) begin
        mb_fault <= 1'b1;
        mb_fcnt  <= b_fault_clr ? 8'd1 : ((mb_fcnt == 8'd255) ? 8'd255 : mb_fcnt + 8'd1);
      end else if (FD && b_fault_clr) begin
        mb_fault <= 1'b0; mb_fcnt <= 8'd0;
      end
    end
  end

  // {in_ready, out_valid, phase_eval, out_t, out_f, fault, fault_cnt}
  logic [27:0] act_a, act_b, exp_a, exp_b;
  assign act_a = {a_in_ready, a_out_valid, a_phase_eval, a_out_t, a_out_f, a_fault, a_fault_cnt};
  assign act_b = {b_in_ready, b_out_valid, b_phase_eval, b_out_t, b_out_f, b_fault, b_fault_cnt};
  assign exp_a = {(!ma_busy && ma_idle >= A_PRE), ma_busy, ma_busy,
                  ma_busy ? ma_t : 8'h00, ma_busy ? ma_f : 8'h00, ma_fault, ma_fcnt};
  assign exp_b = {(!mb_busy && mb_idle >= B_PRE), mb_busy, mb_busy,
                  mb_busy ? mb_t : 8'h00, mb_busy ? mb_f : 8'h00, mb_fault, mb_fcnt};

  int checks = 0;
  int errors = 0;

  // Advance to the next negedge at which in_ready is high (bounded).
  task automatic wait_ready_a(output bit ok);
    ok = a_in_ready;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = a_in_ready;
    end
  endtask

  task automatic wait_ready_b(output bit ok);
    ok = b_in_ready;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = b_in_ready;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int first_a, first_b;
    logic [16:0] idle_out;
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_in_t = 0; a_in_f = 0; a_fault_clr = 0;
    b_in_valid = 0; b_out_ready = 0; b_in_t = 0; b_in_f = 0; b_fault_clr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (act_a !== 28'h0) begin errors++; $display("FAIL reset_a: got %h expected %h", act_a, 28'h0); end
    checks++;
    if (act_b !== 28'h0) begin errors++; $display("FAIL reset_b: got %h expected %h", act_b, 28'h0); end
    rst_n = 1'b1;
    first_a = -1; first_b = -1; idle_out = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (act_a !== exp_a) begin errors++; $display("FAIL idle_a cyc %0d: got %h expected %h", k, act_a, exp_a); end
      checks++;
      if (act_b !== exp_b) begin errors++; $display("FAIL idle_b cyc %0d: got %h expected %h", k, act_b, exp_b); end
      if (a_in_ready === 1'b1 && first_a < 0) first_a = k;
      if (b_in_ready === 1'b1 && first_b < 0) first_b = k;
      idle_out = idle_out | {a_out_valid, a_out_t, a_out_f};
    end
    checks++;
    if (first_a != A_PRE) begin errors++; $display("FAIL first_ready_a: got %0d expected %0d", first_a, A_PRE); end
    checks++;
    if (first_b != B_PRE) begin errors++; $display("FAIL first_ready_b: got %0d expected %0d", first_b, B_PRE); end
    checks++;
    if (idle_out !== 17'h0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", idle_out); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_directed_a5();
    bit ok;
    a_out_ready = 1'b1;
    wait_ready_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL a5_ready_timeout: got 0 expected 1"); end
    a_in_t = 8'hA5; a_in_f = 8'h5A; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_out_t, a_out_f, a_in_ready} !== {1'b1, 8'h5A, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL a5_eval: got v=%b t=%h f=%h r=%b expected v=1 t=5a f=a5 r=0",
                         a_out_valid, a_out_t, a_out_f, a_in_ready);
    end
    checks++;
    if (act_a !== exp_a) begin errors++; $display("FAIL a5_model: got %h expected %h", act_a, exp_a); end
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_phase_eval, a_out_t, a_out_f, a_in_ready} !== 19'h0) begin
      errors++; $display("FAIL a5_precharge: got v=%b p=%b t=%h f=%h r=%b expected all 0",
                         a_out_valid, a_phase_eval, a_out_t, a_out_f, a_in_ready);
    end
    @(negedge clk);
    checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      errors++; $display("FAIL a5_ready_return: got r=%b v=%b expected r=1 v=0", a_in_ready, a_out_valid);
    end
    $display("test_directed_a5 done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_eval_hold();
    bit ok;
    int n;
    b_out_ready = 1'b1;
    wait_ready_b(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_ready_timeout1: got 0 expected 1"); end
    b_in_t = 8'($urandom); b_in_f = ~b_in_t; b_in_valid = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      if (!b_out_valid) break;
      n++;
      checks++;
      if (act_b !== exp_b) begin errors++; $display("FAIL hold_model1 cyc %0d: got %h expected %h", k, act_b, exp_b); end
    end
    checks++;
    if (n != B_EVAL) begin errors++; $display("FAIL hold_len_ready_high: got %0d expected %0d", n, B_EVAL); end

    wait_ready_b(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_ready_timeout2: got 0 expected 1"); end
    b_out_ready = 1'b0;
    b_in_t = 8'($urandom); b_in_f = ~b_in_t; b_in_valid = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      if (!b_out_valid) break;
      n++;
      checks++;
      if (act_b !== exp_b) begin errors++; $display("FAIL hold_model2 cyc %0d: got %h expected %h", k, act_b, exp_b); end
      b_out_ready = (k >= 5);
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL hold_len_late_ready: got %0d expected 5", n); end
    b_out_ready = 1'b1;
    $display("test_eval_hold done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    bit ok;
    int acc, last, gap_bad;
    a_out_ready = 1'b1;
    wait_ready_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_ready_timeout: got 0 expected 1"); end
    a_in_valid = 1'b1;
    acc = 0; last = -100; gap_bad = 0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (act_a !== exp_a) begin errors++; $display("FAIL b2b_model cyc %0d: got %h expected %h", k, act_a, exp_a); end
      if (a_in_ready === 1'b1) begin
        acc++;
        if (acc > 1 && (k - last) != 3) gap_bad++;
        last = k;
      end
      a_in_t = 8'($urandom); a_in_f = ~a_in_t;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    checks++;
    if (acc != 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_eval();
    bit ok;
    int first;
    b_out_ready = 1'b0;
    wait_ready_b(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_ready_timeout: got 0 expected 1"); end
    b_in_t = 8'($urandom); b_in_f = ~b_in_t; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b1) begin errors++; $display("FAIL mid_held: got %b expected 1", b_out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (act_b !== 28'h0) begin errors++; $display("FAIL mid_reset_clear: got %h expected %h", act_b, 28'h0); end
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    first = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (act_b !== exp_b) begin errors++; $display("FAIL mid_model cyc %0d: got %h expected %h", k, act_b, exp_b); end
      if (b_in_ready === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != B_PRE) begin errors++; $display("FAIL mid_first_ready: got %0d expected %0d", first, B_PRE); end
    $display("test_reset_mid_eval done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fault();
    bit ok;
    int tout;
    logic [8:0] want;
    a_out_ready = 1'b1;
    a_fault_clr = 1'b1;
    @(negedge clk);
    a_fault_clr = 1'b0;
    wait_ready_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fault_ready_timeout: got 0 expected 1"); end
    a_in_t = 8'h01; a_in_f = 8'h01; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    want = FD ? 9'h101 : 9'h000;
    checks++;
    if ({a_fault, a_fault_cnt} !== want) begin
      errors++; $display("FAIL fault_first: got f=%b cnt=%0d expected %h", a_fault, a_fault_cnt, want);
    end
    checks++;
    if ({a_out_t, a_out_f} !== 16'h0101) begin
      errors++; $display("FAIL fault_passthrough: got t=%h f=%h expected 01 01", a_out_t, a_out_f);
    end
    tout = 0;
    for (int i = 0; i < 299; i++) begin
      wait_ready_a(ok);
      if (!ok) tout++;
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
    end
    checks++;
    if (tout != 0) begin errors++; $display("FAIL fault_loop_timeouts: got %0d expected 0", tout); end
    want = FD ? 9'h1FF : 9'h000;
    checks++;
    if ({a_fault, a_fault_cnt} !== want) begin
      errors++; $display("FAIL fault_saturate: got f=%b cnt=%0d expected %h", a_fault, a_fault_cnt, want);
    end
    a_fault_clr = 1'b1;
    @(negedge clk);
    a_fault_clr = 1'b0;
    checks++;
    if ({a_fault, a_fault_cnt} !== 9'h000) begin
      errors++; $display("FAIL fault_clear: got f=%b cnt=%0d expected 0", a_fault, a_fault_cnt);
    end
    wait_ready_a(ok);
    a_in_valid = 1'b1; a_fault_clr = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_fault_clr = 1'b0;
    want = FD ? 9'h101 : 9'h000;
    checks++;
    if ({a_fault, a_fault_cnt} !== want) begin
      errors++; $display("FAIL fault_clr_vs_new: got f=%b cnt=%0d expected %h", a_fault, a_fault_cnt, want);
    end
    checks++;
    if (act_a !== exp_a) begin errors++; $display("FAIL fault_model: got %h expected %h", act_a, exp_a); end
    a_in_t = 8'h0F; a_in_f = 8'hF0;
    $display("test_fault done: checks=%0d errors=%0d", checks, errors);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if (act_a !== exp_a) begin errors++; $display("FAIL rand_a cyc %0d: got %h expected %h", k, act_a, exp_a); end
      checks++;
      if (act_b !== exp_b) begin errors++; $display("FAIL rand_b cyc %0d: got %h expected %h", k, act_b, exp_b); end
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_t      = 8'($urandom);
      a_in_f      = ($urandom_range(0, 5) == 0) ? 8'($urandom) : ~a_in_t;
      a_fault_clr = ($urandom_range(0, 15) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_t      = 8'($urandom);
      b_in_f      = ($urandom_range(0, 5) == 0) ? 8'($urandom) : ~b_in_t;
      b_fault_clr = ($urandom_range(0, 15) == 0);
    end
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_directed_a5();
    test_eval_hold();
    test_back_to_back();
    test_reset_mid_eval();
    test_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
